// File: rtl/mdu_pkg.sv
// Shared types and elaboration helpers for the HI/LO multiply sequencer.
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  // Counter width able to hold WIDTH/BITS_PER_CYCLE itself.
  function automatic int cnt_w(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

  function automatic bit bpc_legal(input int width, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// Combinational shift-add step: adds multiplicand * multiplier slice, shifted to pos.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BPC   = 1,
  parameter int POS_W = 6
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [BPC-1:0]     slice,
  input  logic [POS_W-1:0]   pos,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] pp;

  always_comb begin
    pp       = {{WIDTH{1'b0}}, mcand} * {{(2*WIDTH-BPC){1'b0}}, slice};
    acc_next = acc + (pp << pos);
  end

endmodule

// File: rtl/hilo_mdu_seq.sv
// Iterative MULTU sequencer owning HI/LO, with MFHI/MFLO stall generation.
// Optional signed MULT support is enabled with the MDU_SIGNED_EN macro.
module hilo_mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_signed,
  input  logic             mf_req,
  input  logic             mf_sel,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mf_data
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = cnt_w(WIDTH, BITS_PER_CYCLE);
  localparam int POS_W = $clog2(2 * WIDTH);

  if (!bpc_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("hilo_mdu_seq: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
  end

  mdu_state_e state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] commit_val;
  logic [CNT_W-1:0]   count;
  logic [POS_W-1:0]   pos;
  logic [WIDTH-1:0]   a_load;
  logic [WIDTH-1:0]   b_load;

  mdu_step #(
    .WIDTH(WIDTH),
    .BPC  (BITS_PER_CYCLE),
    .POS_W(POS_W)
  ) u_step (
    .acc     (acc),
    .mcand   (mcand),
    .slice   (mplier[BITS_PER_CYCLE-1:0]),
    .pos     (pos),
    .acc_next(acc_next)
  );

`ifdef MDU_SIGNED_EN
  logic neg;

  always_comb begin
    a_load = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    b_load = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg <= 1'b0;
    end else if (start) begin
      neg <= op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end
  end

  assign commit_val = neg ? -acc_next : acc_next;
`else
  logic unused_op_signed;

  assign unused_op_signed = op_signed;
  assign a_load           = op_a;
  assign b_load           = op_b;
  assign commit_val       = acc_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A new start always wins: it reloads even mid-RUN or in DONE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (start)                     state_next = RUN;
        else if (count == CNT_W'(1))   state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      pos    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (start) begin
      mcand  <= a_load;
      mplier <= b_load;
      acc    <= '0;
      count  <= CNT_W'(STEPS);
      pos    <= '0;
    end else if (state == RUN) begin
      acc    <= acc_next;
      mplier <= mplier >> BITS_PER_CYCLE;
      count  <= count - CNT_W'(1);
      pos    <= pos + POS_W'(BITS_PER_CYCLE);
      if (count == CNT_W'(1)) begin
        {hi, lo} <= commit_val;
      end
    end
  end

  assign stall   = mf_req & (busy | start);
  assign mf_data = mf_sel ? lo : hi;

endmodule

// File: tb/tb_hilo_mdu_seq.sv
// Directed bench for hilo_mdu_seq: one BITS_PER_CYCLE=1 and one BITS_PER_CYCLE=4 instance.
module tb_hilo_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, op_signed, mf_req, mf_sel;
  logic [31:0] op_a, op_b;
  logic        busy, done, stall;
  logic [31:0] hi, lo, mf_data;

  logic        start4;
  logic [31:0] op_a4, op_b4;
  logic        busy4, done4, stall4;
  logic [31:0] hi4, lo4, mf_data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hilo_mdu_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .op_signed(op_signed), .mf_req(mf_req), .mf_sel(mf_sel),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .mf_data(mf_data)
  );

  hilo_mdu_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op_a(op_a4), .op_b(op_b4),
    .op_signed(1'b0), .mf_req(1'b0), .mf_sel(1'b0),
    .busy(busy4), .done(done4), .stall(stall4), .hi(hi4), .lo(lo4), .mf_data(mf_data4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on the 1-bit instance; lat counts cycles from the start edge to done.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output int run_cycles, output int lat);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_cycles = 0;
    lat = 1;
    while (!done && lat < 100) begin
      if (busy) run_cycles++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start4 = 1'b0; op_signed = 1'b0;
    mf_req = 1'b0; mf_sel = 1'b0; op_a = '0; op_b = '0; op_a4 = '0; op_b4 = '0;
    tick(); tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, stall} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {busy, done, stall});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo});
    end
    checks++;
    if ({busy4, hi4, lo4} !== 65'h0) begin
      errors++; $display("FAIL reset_dut4 got %h want 0", {busy4, hi4, lo4});
    end
  endtask

  task automatic test_basic();
    int rc, lat;
    do_mul(32'd3, 32'd5, rc, lat);
    checks++;
    if (rc !== 32 || lat !== 33) begin
      errors++; $display("FAIL basic_latency got run=%0d lat=%0d want run=32 lat=33", rc, lat);
    end
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_000F) begin
      errors++; $display("FAIL basic_product got %h want 000000000000000f", {hi, lo});
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL basic_done_pulse got busy,done=%b want 00", {busy, done});
    end
  endtask

  task automatic test_max();
    int rc, lat;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, rc, lat);
    checks++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001 || lat !== 33) begin
      errors++; $display("FAIL max_product got %h lat=%0d want fffffffe00000001 lat=33", {hi, lo}, lat);
    end
    tick();
  endtask

  task automatic test_bpc4();
    int lat;
    op_a4 = 32'hFFFF_FFFF; op_b4 = 32'hFFFF_FFFF; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL bpc4_latency got %0d want 9", lat);
    end
    checks++;
    if ({hi4, lo4} !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL bpc4_product got %h want fffffffe00000001", {hi4, lo4});
    end
    op_a4 = 32'h1234_5678; op_b4 = 32'h0000_0100; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    repeat (8) tick();
    checks++;
    if (done4 !== 1'b1 || {hi4, lo4} !== 64'h0000_0012_3456_7800) begin
      errors++; $display("FAIL bpc4_shift got done=%b %h want done=1 0000001234567800", done4, {hi4, lo4});
    end
    tick();
  endtask

  task automatic test_stall();
    int lat;
    int bad;
    mf_req = 1'b1; mf_sel = 1'b1;
    op_a = 32'd7; op_b = 32'd6; start = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL stall_start_cycle got %b want 1", stall);
    end
    tick();
    start = 1'b0;
    lat = 1; bad = 0;
    while (!done && lat < 100) begin
      if (stall !== 1'b1) bad++;
      tick();
      lat++;
    end
    checks++;
    if (bad !== 0 || lat !== 33) begin
      errors++; $display("FAIL stall_run got %0d cycles without stall lat=%0d want 0 lat=33", bad, lat);
    end
    checks++;
    if (stall !== 1'b0 || mf_data !== 32'h0000_002A) begin
      errors++; $display("FAIL stall_done got stall=%b mf_data=%h want 0 0000002a", stall, mf_data);
    end
    tick();
    checks++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_idle got stall=%b busy=%b want 0 0", stall, busy);
    end
    mf_sel = 1'b0;
    #1;
    checks++;
    if (mf_data !== 32'h0) begin
      errors++; $display("FAIL mf_hi_sel got %h want 00000000", mf_data);
    end
    mf_req = 1'b0;
  endtask

  task automatic test_abort();
    int lat, dones, held_bad;
    op_a = 32'd2; op_b = 32'd2; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    op_a = 32'd10; op_b = 32'd10; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1; dones = 0; held_bad = 0;
    while (!done && lat < 100) begin
      if ({hi, lo} !== 64'h0000_0000_0000_002A) held_bad++;
      tick();
      lat++;
    end
    checks++;
    if (held_bad !== 0 || lat !== 33) begin
      errors++; $display("FAIL abort_hold got %0d bad cycles lat=%0d want 0 lat=33", held_bad, lat);
    end
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_0064) begin
      errors++; $display("FAIL abort_product got %h want 0000000000000064", {hi, lo});
    end
    for (int i = 0; i < 4; i++) begin
      if (done) dones++;
      tick();
    end
    checks++;
    if (dones !== 1) begin
      errors++; $display("FAIL abort_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_reset_mid();
    int rc, lat;
    op_a = 32'd5; op_b = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00 || {hi, lo} !== 64'h0) begin
      errors++; $display("FAIL reset_mid got busy,done=%b hilo=%h want 00 0", {busy, done}, {hi, lo});
    end
    do_mul(32'd4, 32'd4, rc, lat);
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_0010 || lat !== 33) begin
      errors++; $display("FAIL reset_mid_after got %h lat=%0d want 0000000000000010 lat=33", {hi, lo}, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int rc, lat;
    do_mul(32'd3, 32'd5, rc, lat);
    op_a = 32'd100; op_b = 32'd100; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || lo !== 32'h0000_000F) begin
      errors++; $display("FAIL b2b_restart got busy=%b lo=%h want 1 0000000f", busy, lo);
    end
    lat = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if ({hi, lo} !== 64'h0000_0000_0000_2710 || lat !== 33) begin
      errors++; $display("FAIL b2b_product got %h lat=%0d want 0000000000002710 lat=33", {hi, lo}, lat);
    end
    tick();
  endtask

  task automatic test_signed();
    int rc, lat;
    logic [63:0] exp;
`ifdef MDU_SIGNED_EN
    exp = 64'hFFFF_FFFF_FFFF_FFFA;
`else
    exp = 64'h0000_0002_FFFF_FFFA;
`endif
    op_signed = 1'b1;
    do_mul(32'hFFFF_FFFE, 32'd3, rc, lat);
    op_signed = 1'b0;
    checks++;
    if ({hi, lo} !== exp) begin
      errors++; $display("FAIL signed_product got %h want %h", {hi, lo}, exp);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_bpc4();
    test_stall();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_signed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
